ifu_fetch: RTL and testbench

//  Parametrised instruction fetch unit; replaces the NOP-generating IFU stub.

---
 rtl/ifu_pkg.sv | 19 +
 rtl/ifu_fetch_fifo.sv | 51 +++++
 rtl/ifu_fetch.sv | 150 +++++++++++++++
 tb/tb_ifu_fetch.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types for the instruction fetch unit: entry layout, FSM states and fetch step.
package ifu_pkg;

  localparam int IFU_PC_W   = 32;
  localparam int IFU_INST_W = 32;
  localparam int IFU_STEP   = IFU_INST_W / 8;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } ifu_state_e;

  typedef struct packed {
    logic [IFU_PC_W-1:0]   pc;
    logic [IFU_INST_W-1:0] inst;
    logic                  fault;
  } ifu_entry_t;

endpackage

// File: rtl/ifu_fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; serves as fetch buffer and in-flight PC queue.
module ifu_fetch_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  ifu_entry_t             din,
  input  logic                   pop,
  output ifu_entry_t             head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  ifu_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage is cleared on reset so an empty buffer presents an all-zero head.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: sequential PCs, credit-limited in-order fetch, buffered delivery, redirect flush.
// Define IFU_MISALIGN_CHK_EN to add the ifu_fault port and the FAULT state for misaligned redirects.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter int                  ADDR_WIDTH = 32,
  parameter int                  DATA_WIDTH = 32,
  parameter int                  PC_WIDTH   = 32,
  parameter int                  INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter int                  FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ifu_req_addr_vld,
  output logic [ADDR_WIDTH-1:0] ifu_req_addr,
  input  logic                  ifu_req_rdy,
  input  logic                  ifu_req_data_vld,
  input  logic [DATA_WIDTH-1:0] ifu_req_data,
  output logic                  ifu_valid,
  input  logic                  ifu_ready,
  output logic [PC_WIDTH-1:0]   ifu_pc,
  output logic [INST_WIDTH-1:0] ifu_inst,
  input  logic                  ifu_redirect_vld,
  input  logic [PC_WIDTH-1:0]   ifu_redirect_pc
`ifdef IFU_MISALIGN_CHK_EN
  ,
  output logic                  ifu_fault
`endif
);
  localparam int                  STEP       = INST_WIDTH / 8;
  localparam int                  CW         = $clog2(FIFO_DEPTH + 1);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = PC_WIDTH'(STEP - 1);

  ifu_state_e          state, state_n;
  logic [PC_WIDTH-1:0] fetch_pc, redirect_target;
  logic [CW-1:0]       outstanding, drop_cnt, buf_count, pcq_count;
  logic                req_fire, resp_keep, resp_drop, fault_push;
  ifu_entry_t          buf_head, buf_din, pcq_head, pcq_din;
  logic                buf_push, buf_full, buf_empty;
  logic                pcq_full, pcq_empty;
  logic                unused_bits;

  // Credits count both buffered and in-flight words so a response can never find the buffer full.
  assign ifu_req_addr_vld = !rst && (state == RUN) && !ifu_redirect_vld &&
                            (({1'b0, buf_count} + {1'b0, outstanding}) < (CW+1)'(FIFO_DEPTH));
  assign ifu_req_addr     = fetch_pc;
  assign req_fire         = ifu_req_addr_vld && ifu_req_rdy;
  assign resp_drop        = ifu_req_data_vld && (drop_cnt != '0);
  assign resp_keep        = ifu_req_data_vld && (drop_cnt == '0) && !ifu_redirect_vld;

`ifdef IFU_MISALIGN_CHK_EN
  logic fault_pending;
  assign redirect_target = ifu_redirect_pc;
  assign fault_push      = (state == FAULT) && fault_pending && !ifu_redirect_vld;
  assign ifu_fault       = buf_head.fault;
  assign unused_bits     = ^{pcq_head.inst, pcq_head.fault};
`else
  assign redirect_target = ifu_redirect_pc & ~ALIGN_MASK;
  assign fault_push      = 1'b0;
  assign unused_bits     = ^{pcq_head.inst, pcq_head.fault, buf_head.fault};
`endif

  always_comb begin
    buf_din.pc    = pcq_head.pc;
    buf_din.inst  = ifu_req_data;
    buf_din.fault = 1'b0;
    buf_push      = resp_keep;
    if (fault_push) begin
      buf_din.pc    = fetch_pc;
      buf_din.inst  = '0;
      buf_din.fault = 1'b1;
      buf_push      = 1'b1;
    end
  end

  always_comb begin
    pcq_din.pc    = fetch_pc;
    pcq_din.inst  = '0;
    pcq_din.fault = 1'b0;
  end

  ifu_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_buf (
    .clk(clk), .rst(rst), .flush(ifu_redirect_vld),
    .push(buf_push), .din(buf_din), .pop(ifu_valid && ifu_ready && !ifu_redirect_vld),
    .head(buf_head), .count(buf_count), .full(buf_full), .empty(buf_empty)
  );

  ifu_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_pcq (
    .clk(clk), .rst(rst), .flush(ifu_redirect_vld),
    .push(req_fire), .din(pcq_din), .pop(resp_keep),
    .head(pcq_head), .count(pcq_count), .full(pcq_full), .empty(pcq_empty)
  );

  assign ifu_valid = !buf_empty;
  assign ifu_pc    = buf_head.pc;
  assign ifu_inst  = buf_head.inst;

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
`ifdef IFU_MISALIGN_CHK_EN
    if (ifu_redirect_vld)
      state_n = ((ifu_redirect_pc & ALIGN_MASK) != '0) ? FAULT : RUN;
`else
    state_n = RUN;
`endif
  end

  // Responses already in flight at a redirect still arrive and must be swallowed.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(ifu_req_data_vld);
      if (ifu_redirect_vld) begin
        fetch_pc <= redirect_target;
        drop_cnt <= outstanding - CW'(ifu_req_data_vld);
      end else begin
        if (req_fire)  fetch_pc <= fetch_pc + PC_WIDTH'(STEP);
        if (resp_drop) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

`ifdef IFU_MISALIGN_CHK_EN
  always_ff @(posedge clk) begin
    if (rst)                   fault_pending <= 1'b0;
    else if (ifu_redirect_vld) fault_pending <= ((ifu_redirect_pc & ALIGN_MASK) != '0);
    else if (fault_push)       fault_pending <= 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(buf_push && buf_full));
      assert (!(ifu_req_data_vld && (outstanding == '0)));
      assert (!(req_fire && pcq_full));
      assert (!(resp_keep && pcq_empty));
      assert ((pcq_count + drop_cnt) == outstanding);
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized self-checking bench for ifu_fetch against a stream-level reference model.
// The IFU_MISALIGN_CHK_EN build additionally exercises the fault entry path.
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_addr_vld;
  logic [31:0] ifu_req_addr;
  logic        ifu_req_rdy;
  logic        ifu_req_data_vld;
  logic [31:0] ifu_req_data;
  logic        ifu_valid;
  logic        ifu_ready;
  logic [31:0] ifu_pc;
  logic [31:0] ifu_inst;
  logic        ifu_redirect_vld;
  logic [31:0] ifu_redirect_pc;
`ifdef IFU_MISALIGN_CHK_EN
  logic        ifu_fault;
`endif

  always #5 clk = ~clk;

  ifu_fetch #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .PC_WIDTH(32), .INST_WIDTH(32),
    .RESET_PC(RESET_PC), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .ifu_req_addr_vld(ifu_req_addr_vld), .ifu_req_addr(ifu_req_addr), .ifu_req_rdy(ifu_req_rdy),
    .ifu_req_data_vld(ifu_req_data_vld), .ifu_req_data(ifu_req_data),
    .ifu_valid(ifu_valid), .ifu_ready(ifu_ready), .ifu_pc(ifu_pc), .ifu_inst(ifu_inst),
    .ifu_redirect_vld(ifu_redirect_vld), .ifu_redirect_pc(ifu_redirect_pc)
`ifdef IFU_MISALIGN_CHK_EN
    , .ifu_fault(ifu_fault)
`endif
  );

  int          total = 0;
  int          bad = 0;
  int          delivered = 0;
  int          req_count = 0;
  logic [31:0] mem_q[$];
  logic [31:0] exp_req, exp_dec, last_dec_pc, prev_addr;
  bit          prev_stall, mem_hold, resp_rand, model_fault, fault_done;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // One clock of stimulus: memory response, sampling, model update; entered and left at negedge.
  task automatic tick();
    logic        hs_req, hs_dec, redir;
    logic [31:0] tgt;
    ifu_req_data_vld = 1'b0;
    ifu_req_data     = '0;
    if (mem_q.size() > 0 && !mem_hold && (!resp_rand || $urandom_range(0, 2) != 0)) begin
      ifu_req_data_vld = 1'b1;
      ifu_req_data     = mem_word(mem_q.pop_front());
    end
    #1;
    redir  = ifu_redirect_vld;
    hs_req = ifu_req_addr_vld && ifu_req_rdy;
    hs_dec = ifu_valid && ifu_ready && !redir;
    if (prev_stall && !redir) begin
      total++;
      if (ifu_req_addr_vld !== 1'b1 || ifu_req_addr !== prev_addr) begin
        bad++;
        $display("[TB] FAIL req_hold: vld=%0b addr=%h required vld=1 addr=%h", ifu_req_addr_vld, ifu_req_addr, prev_addr);
      end
    end
    if (redir) begin
      total++;
      if (ifu_req_addr_vld !== 1'b0) begin
        bad++;
        $display("[TB] FAIL redirect_no_req: vld=%0b required 0", ifu_req_addr_vld);
      end
    end
`ifdef IFU_MISALIGN_CHK_EN
    if (model_fault && !redir) begin
      total++;
      if (ifu_req_addr_vld !== 1'b0) begin
        bad++;
        $display("[TB] FAIL fault_no_req: vld=%0b required 0", ifu_req_addr_vld);
      end
    end
`endif
    if (hs_req) begin
      total++;
      if (ifu_req_addr !== exp_req) begin
        bad++;
        $display("[TB] FAIL req_addr: got %h required %h", ifu_req_addr, exp_req);
      end
      mem_q.push_back(ifu_req_addr);
      exp_req = exp_req + 32'd4;
      req_count++;
    end
    if (hs_dec) begin
      delivered++;
      last_dec_pc = ifu_pc;
      total++;
`ifdef IFU_MISALIGN_CHK_EN
      if (model_fault) begin
        if (fault_done || ifu_pc !== exp_dec || ifu_inst !== 32'h0 || ifu_fault !== 1'b1) begin
          bad++;
          $display("[TB] FAIL fault_entry: pc=%h inst=%h fault=%0b required pc=%h inst=0 fault=1 once", ifu_pc, ifu_inst, ifu_fault, exp_dec);
        end
        fault_done = 1'b1;
      end else begin
        if (ifu_pc !== exp_dec || ifu_inst !== mem_word(exp_dec) || ifu_fault !== 1'b0) begin
          bad++;
          $display("[TB] FAIL deliver: pc=%h inst=%h fault=%0b required pc=%h inst=%h fault=0", ifu_pc, ifu_inst, ifu_fault, exp_dec, mem_word(exp_dec));
        end
        exp_dec = exp_dec + 32'd4;
      end
`else
      if (ifu_pc !== exp_dec || ifu_inst !== mem_word(exp_dec)) begin
        bad++;
        $display("[TB] FAIL deliver: pc=%h inst=%h required pc=%h inst=%h", ifu_pc, ifu_inst, exp_dec, mem_word(exp_dec));
      end
      exp_dec = exp_dec + 32'd4;
`endif
    end
    if (redir) begin
      tgt = ifu_redirect_pc;
`ifdef IFU_MISALIGN_CHK_EN
      model_fault = (tgt[1:0] != 2'b00);
      fault_done  = 1'b0;
`else
      tgt[1:0] = 2'b00;
`endif
      exp_req = tgt;
      exp_dec = tgt;
    end
    prev_stall = !redir && ifu_req_addr_vld && !ifu_req_rdy;
    prev_addr  = ifu_req_addr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic redirect(input logic [31:0] pc);
    ifu_redirect_vld = 1'b1;
    ifu_redirect_pc  = pc;
    tick();
    ifu_redirect_vld = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifu_req_rdy = 1'b0; ifu_ready = 1'b0; ifu_redirect_vld = 1'b0; ifu_redirect_pc = '0;
    ifu_req_data_vld = 1'b0; ifu_req_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total += 4;
    if (ifu_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %0b required 0", ifu_valid); end
    if (ifu_req_addr_vld !== 1'b0) begin bad++; $display("[TB] FAIL reset_req_vld: got %0b required 0", ifu_req_addr_vld); end
    if (ifu_pc !== 32'h0) begin bad++; $display("[TB] FAIL reset_pc: got %h required 0", ifu_pc); end
    if (ifu_inst !== 32'h0) begin bad++; $display("[TB] FAIL reset_inst: got %h required 0", ifu_inst); end
    mem_q.delete();
    exp_req = RESET_PC; exp_dec = RESET_PC;
    prev_stall = 1'b0; model_fault = 1'b0; fault_done = 1'b0; mem_hold = 1'b0; resp_rand = 1'b0;
    rst = 1'b0;
  endtask

  task automatic drain();
    ifu_req_rdy = 1'b0; ifu_ready = 1'b1; mem_hold = 1'b0; resp_rand = 1'b0;
    for (int i = 0; i < 40 && (ifu_valid || mem_q.size() != 0); i++) tick();
    total++;
    if (ifu_valid !== 1'b0 || mem_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: valid=%0b pending=%0d required valid=0 pending=0", ifu_valid, mem_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_sequential();
    int d0;
    d0 = delivered;
    ifu_req_rdy = 1'b1; ifu_ready = 1'b1;
    repeat (30) tick();
    total++;
    if (delivered - d0 != 28) begin
      bad++;
      $display("[TB] FAIL back_to_back: delivered %0d required 28", delivered - d0);
    end
  endtask

  task automatic test_backpressure();
    int r0, d0;
    drain();
    r0 = req_count;
    ifu_req_rdy = 1'b1; ifu_ready = 1'b0;
    repeat (12) tick();
    total += 3;
    if (req_count - r0 != 4) begin bad++; $display("[TB] FAIL credit_reqs: got %0d required 4", req_count - r0); end
    if (ifu_req_addr_vld !== 1'b0) begin bad++; $display("[TB] FAIL credit_vld: got %0b required 0", ifu_req_addr_vld); end
    if (ifu_valid !== 1'b1) begin bad++; $display("[TB] FAIL credit_valid: got %0b required 1", ifu_valid); end
    d0 = delivered;
    ifu_ready = 1'b1;
    repeat (20) tick();
    total++;
    if (delivered - d0 < 16) begin bad++; $display("[TB] FAIL resume: delivered %0d required >=16", delivered - d0); end
  endtask

  task automatic test_redirect_inflight();
    int r0, d0;
    drain();
    mem_hold = 1'b1; ifu_req_rdy = 1'b1; ifu_ready = 1'b1;
    r0 = req_count;
    repeat (3) tick();
    total++;
    if (req_count - r0 != 3) begin bad++; $display("[TB] FAIL inflight_setup: reqs %0d required 3", req_count - r0); end
    ifu_req_rdy = 1'b0;
    redirect(32'h100);
    total++;
    if (ifu_valid !== 1'b0) begin bad++; $display("[TB] FAIL redirect_flush: valid=%0b required 0", ifu_valid); end
    mem_hold = 1'b0; ifu_req_rdy = 1'b1;
    d0 = delivered;
    for (int i = 0; i < 20 && delivered == d0; i++) tick();
    total++;
    if (delivered == d0 || last_dec_pc !== 32'h100) begin
      bad++;
      $display("[TB] FAIL redirect_first: delivered %0d pc=%h required pc=00000100", delivered - d0, last_dec_pc);
    end
  endtask

  task automatic test_redirect_collision();
    int d0;
    drain();
    ifu_req_rdy = 1'b1; ifu_ready = 1'b0;
    repeat (2) tick();
    total++;
    if (ifu_valid !== 1'b1) begin bad++; $display("[TB] FAIL collide_setup: valid=%0b required 1", ifu_valid); end
    ifu_ready = 1'b1;
    redirect(32'h300);
    ifu_req_rdy = 1'b0;
    d0 = delivered;
    repeat (3) tick();
    total++;
    if (delivered != d0 || ifu_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL collide_drop: delivered %0d valid=%0b required 0 and 0", delivered - d0, ifu_valid);
    end
    ifu_req_rdy = 1'b1;
    for (int i = 0; i < 20 && delivered == d0; i++) tick();
    total++;
    if (delivered == d0 || last_dec_pc !== 32'h300) begin
      bad++;
      $display("[TB] FAIL collide_first: delivered %0d pc=%h required pc=00000300", delivered - d0, last_dec_pc);
    end
  endtask

  task automatic test_wrap();
    int d0;
    drain();
    redirect(32'hFFFF_FFF8);
    d0 = delivered;
    ifu_req_rdy = 1'b1; ifu_ready = 1'b1;
    repeat (12) tick();
    total++;
    if (delivered - d0 != 10 || last_dec_pc !== 32'h0000_001C) begin
      bad++;
      $display("[TB] FAIL pc_wrap: delivered %0d last=%h required 10 last=0000001c", delivered - d0, last_dec_pc);
    end
  endtask

  task automatic test_random();
    int d0;
    d0 = delivered;
    resp_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      ifu_req_rdy = 1'($urandom_range(0, 1));
      ifu_ready   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) redirect($urandom & 32'h0003_FFFF);
      else tick();
    end
    drain();
    total++;
    if (delivered - d0 < 10) begin bad++; $display("[TB] FAIL random_progress: delivered %0d required >=10", delivered - d0); end
  endtask

  task automatic test_reset_midway();
    int d0;
    ifu_req_rdy = 1'b1; ifu_ready = 1'b1;
    repeat (5) tick();
    do_reset();
    d0 = delivered;
    ifu_req_rdy = 1'b1; ifu_ready = 1'b1;
    repeat (10) tick();
    total++;
    if (delivered - d0 != 8 || last_dec_pc !== 32'h0000_001C) begin
      bad++;
      $display("[TB] FAIL reset_restart: delivered %0d last=%h required 8 last=0000001c", delivered - d0, last_dec_pc);
    end
  endtask

`ifdef IFU_MISALIGN_CHK_EN
  task automatic test_misalign();
    int d0;
    drain();
    ifu_req_rdy = 1'b1; ifu_ready = 1'b0;
    redirect(32'h102);
    repeat (6) tick();
    total++;
    if (ifu_valid !== 1'b1 || ifu_pc !== 32'h102 || ifu_fault !== 1'b1 || ifu_inst !== 32'h0) begin
      bad++;
      $display("[TB] FAIL misalign_entry: valid=%0b pc=%h fault=%0b inst=%h required 1 102 1 0", ifu_valid, ifu_pc, ifu_fault, ifu_inst);
    end
    d0 = delivered;
    ifu_ready = 1'b1;
    repeat (4) tick();
    total++;
    if (delivered - d0 != 1) begin bad++; $display("[TB] FAIL misalign_single: delivered %0d required 1", delivered - d0); end
    redirect(32'h200);
    d0 = delivered;
    repeat (10) tick();
    total++;
    if (delivered - d0 != 8 || last_dec_pc !== 32'h21C) begin
      bad++;
      $display("[TB] FAIL misalign_recover: delivered %0d last=%h required 8 last=0000021c", delivered - d0, last_dec_pc);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    ifu_req_rdy = 1'b0; ifu_ready = 1'b0; ifu_redirect_vld = 1'b0; ifu_redirect_pc = '0;
    ifu_req_data_vld = 1'b0; ifu_req_data = '0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_collision();
    test_wrap();
    test_random();
    test_reset_midway();
`ifdef IFU_MISALIGN_CHK_EN
    test_misalign();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
